// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_pkg
//  Purpose  : Shared constants for the instruction fetch stage.
//  Contents : INST_W   - instruction / fetch data width
//             INST_NOP - canonical RV32 NOP (addi x0, x0, 0)
//             word_align() - clears the byte offset of an address
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int unsigned INST_W   = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Fetches are always whole words; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : DEPTH-entry circular buffer pairing fetch PCs with returned
//             instruction words. Entries are reserved at request issue
//             (alloc), completed in order as responses return (fill) and
//             released to decode from the head (pop). Flush frees everything.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             i_alloc, i_alloc_pc   - reserve tail entry for a new fetch
//             i_fill, i_fill_inst   - write next unfilled entry
//             i_pop                 - release head entry
//             i_flush               - free all entries (wins over all else)
//             o_count, o_unfilled   - allocated / allocated-but-unfilled
//             o_head_valid/_pc/_inst- head entry, straight from registers
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_alloc,
    input  logic [31:0]       i_alloc_pc,
    input  logic              i_fill,
    input  logic [INST_W-1:0] i_fill_inst,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_unfilled,
    output logic              o_head_valid,
    output logic [31:0]       o_head_pc,
    output logic [INST_W-1:0] o_head_inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_alloc_ptr;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [PTR_W-1:0]  r_head_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_unfilled;
    logic [31:0]       r_pc   [DEPTH];
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [DEPTH-1:0]  r_filled;

    // Alloc never targets the head while it is filled (count < DEPTH), and
    // fill only targets unfilled entries, so the three updates below never
    // collide on the same filled bit with conflicting values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
            r_filled    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
            r_filled    <= '0;
        end else begin
            if (i_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
                r_head_ptr           <= r_head_ptr + PTR_W'(1);
            end
            if (i_alloc) begin
                r_pc[r_alloc_ptr]     <= i_alloc_pc;
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + PTR_W'(1);
            end
            if (i_fill) begin
                r_inst[r_fill_ptr]   <= i_fill_inst;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
            r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(i_fill);
        end
    end

    assign o_count      = r_count;
    assign o_unfilled   = r_unfilled;
    assign o_head_valid = r_filled[r_head_ptr];
    assign o_head_pc    = r_pc[r_head_ptr];
    assign o_head_inst  = r_inst[r_head_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, issues in-order word
//             fetches over a request/response memory port, pairs each
//             returned word with its PC and hands it to decode via
//             valid/ready. Redirects from execute flush the stage; responses
//             for fetches still in flight at a flush are counted and dropped.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             o_imem_req_valid/_addr     - fetch request
//             i_imem_req_ready           - request accepted
//             i_imem_rsp_valid/_rdata    - in-order fetch response
//             i_redirect_valid/_pc       - redirect from execute
//             o_inst_valid/_inst/_inst_pc- instruction to decode
//             i_inst_ready               - decode consumes instruction
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_imem_req_valid,
    output logic [31:0]       o_imem_req_addr,
    input  logic              i_imem_req_ready,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_rdata,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [31:0]       o_inst_pc,
    input  logic              i_inst_ready
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_unfilled;
    logic              w_head_valid;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_drop_active;
    logic              w_fill;
    logic              w_pop;
    logic [CNT_W:0]    w_drop_sum;
    logic [CNT_W-1:0]  w_drop_next;

    // rst_n gates the request so nothing is offered to memory while held
    // in reset, even though the buffer count already reads zero.
    assign w_req_valid   = rst_n && (w_count < c_DEPTH) && !i_redirect_valid;
    assign w_accept      = w_req_valid && i_imem_req_ready;
    assign w_drop_active = (r_drop_cnt != '0);
    assign w_fill        = i_imem_rsp_valid && !w_drop_active && (w_unfilled != '0);
    assign w_pop         = w_head_valid && i_inst_ready;

    // On a redirect every unfilled entry becomes a response to discard; a
    // response arriving in the same cycle is itself one of those, so it is
    // taken off the new total.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_unfilled};
        if (i_imem_rsp_valid && (w_drop_sum != '0)) begin
            w_drop_sum = w_drop_sum - (CNT_W+1)'(1);
        end
        w_drop_next = (w_drop_sum > (CNT_W+1)'(DEPTH)) ? c_DEPTH : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_ADDR;
            r_drop_cnt <= '0;
        end else if (i_redirect_valid) begin
            r_pc       <= word_align(i_redirect_pc);
            r_drop_cnt <= w_drop_next;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (i_imem_rsp_valid && w_drop_active) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_accept),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_inst  (i_imem_rsp_rdata),
        .i_pop        (w_pop),
        .i_flush      (i_redirect_valid),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_head_valid (w_head_valid),
        .o_head_pc    (o_inst_pc),
        .o_head_inst  (o_inst)
    );

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = word_align(r_pc);
    assign o_inst_valid     = w_head_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A bench-side memory returns
//             in-order responses with configurable latency; a reference model
//             tracks the PC, the list of fetches owed to decode and which of
//             them have returned, and checks every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          DEPTH      = 2;

    logic        clk;
    logic        rst_n;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_rdata;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    fetch_unit #(
        .RESET_ADDR (RESET_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_req_ready (i_imem_req_ready),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_rdata (i_imem_rsp_rdata),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .i_inst_ready     (i_inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } mem_t;
    typedef struct { logic [31:0] pc; bit arrived; } exp_t;

    mem_t        mem_q[$];      // requests accepted by memory, not yet answered
    exp_t        exp_q[$];      // fetches owed to decode since the last flush
    int          epoch;
    int          cyc;
    logic [31:0] m_pc;

    int n_total;
    int n_bad;

    // knobs
    int          k_rdy_pct, k_dec_pct, k_redir_pct, k_lat_min, k_lat_max;
    int          redir_mode;    // 0 none, 1 when 2 live fetches in flight, 2 on live response
    logic [31:0] redir_target;
    bit          redir_fired;

    // directed observations
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    int          last_redir_cyc;
    int          first_acc_after_cyc;
    logic [31:0] first_acc_after_addr;
    logic [31:0] first_pop_after_pc;
    bit          got_acc_after, got_pop_after;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mem_q.delete();
        exp_q.delete();
        acc_addr.delete();
        acc_cyc.delete();
        epoch++;
        m_pc = RESET_ADDR;
        got_acc_after = 1'b0;
        got_pop_after = 1'b0;
    endtask

    task automatic drive_idle();
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_rdata = '0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int live_inflight();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic step();
        bit   exp_req, exp_v, acc, pop, rsp, red, fire;
        mem_t m;
        @(posedge clk);
        cyc++;
        #1;
        i_imem_req_ready = ($urandom_range(99) < k_rdy_pct);
        i_inst_ready     = ($urandom_range(99) < k_dec_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_rdata = mem_word(mem_q[0].addr);
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_rdata = $urandom;
        end
        fire = 1'b0;
        if (redir_mode == 1 && live_inflight() >= 2) fire = 1'b1;
        if (redir_mode == 2 && i_imem_rsp_valid && mem_q[0].epoch == epoch) fire = 1'b1;
        if (fire) begin
            redir_mode  = 0;
            redir_fired = 1'b1;
        end else if ($urandom_range(99) < k_redir_pct) begin
            fire = 1'b1;
            redir_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(3)))
                                                    : $urandom;
        end
        i_redirect_valid = fire;
        i_redirect_pc    = fire ? redir_target : $urandom;

        @(negedge clk);
        exp_req = (exp_q.size() < DEPTH) && !i_redirect_valid;
        check("req_valid", {31'd0, o_imem_req_valid}, {31'd0, exp_req});
        if (exp_req) check("req_addr", o_imem_req_addr, m_pc);
        exp_v = (exp_q.size() > 0) && exp_q[0].arrived;
        check("inst_valid", {31'd0, o_inst_valid}, {31'd0, exp_v});
        if (exp_v) begin
            check("inst_pc", o_inst_pc, exp_q[0].pc);
            check("inst", o_inst, mem_word(exp_q[0].pc));
        end

        red = i_redirect_valid;
        rsp = i_imem_rsp_valid;
        acc = exp_req && i_imem_req_ready;
        pop = exp_v && i_inst_ready;
        if (rsp) m = mem_q.pop_front();
        if (red) begin
            exp_q.delete();
            epoch++;
            m_pc           = redir_target & ~32'h3;
            last_redir_cyc = cyc;
            got_acc_after  = 1'b0;
            got_pop_after  = 1'b0;
        end else begin
            if (pop) begin
                if (!got_pop_after) begin
                    first_pop_after_pc = exp_q[0].pc;
                    got_pop_after      = 1'b1;
                end
                void'(exp_q.pop_front());
            end
            if (rsp && m.epoch == epoch) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].arrived) begin
                        exp_q[i].arrived = 1'b1;
                        break;
                    end
                end
            end
            if (acc) begin
                mem_q.push_back('{m_pc, epoch, cyc + $urandom_range(k_lat_max, k_lat_min)});
                exp_q.push_back('{m_pc, 1'b0});
                acc_addr.push_back(m_pc);
                acc_cyc.push_back(cyc);
                if (!got_acc_after) begin
                    first_acc_after_cyc  = cyc;
                    first_acc_after_addr = m_pc;
                    got_acc_after        = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic set_knobs(input int rdy, input int dec, input int lmin, input int lmax, input int redir);
        k_rdy_pct   = rdy;
        k_dec_pct   = dec;
        k_lat_min   = lmin;
        k_lat_max   = lmax;
        k_redir_pct = redir;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        epoch   = 0;
        redir_mode  = 0;
        redir_fired = 1'b0;
        redir_target = '0;
        last_redir_cyc = 0;
        first_acc_after_cyc = 0;
        first_acc_after_addr = '0;
        first_pop_after_pc = '0;
        rst_n = 1'b0;
        drive_idle();
        set_knobs(100, 100, 1, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // streaming, 1-cycle memory, decode always ready
        repeat (12) step();
        check("stream_n_acc", 32'(acc_addr.size() >= 3), 32'd1);
        if (acc_addr.size() >= 3) begin
            check("stream_a0", acc_addr[0], 32'h0);
            check("stream_a1", acc_addr[1], 32'h4);
            check("stream_a2", acc_addr[2], 32'h8);
            check("stream_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        end

        // decode stalled: only DEPTH fetches may be outstanding
        do_reset();
        set_knobs(100, 0, 1, 1, 0);
        repeat (6) step();
        check("stall_n_acc", 32'(acc_addr.size()), 32'd2);
        k_dec_pct = 100;
        repeat (8) step();
        check("resume_n_acc", 32'(acc_addr.size() >= 3), 32'd1);
        if (acc_addr.size() >= 3) check("resume_addr", acc_addr[2], 32'h8);

        // redirect with two live fetches in flight, 3-cycle memory
        do_reset();
        set_knobs(100, 100, 3, 3, 0);
        repeat (6) step();
        redir_target = 32'h0000_0100;
        redir_fired  = 1'b0;
        redir_mode   = 1;
        repeat (20) step();
        check("redir1_fired", {31'd0, redir_fired}, 32'd1);
        check("redir1_acc_lat", 32'(first_acc_after_cyc - last_redir_cyc), 32'd1);
        check("redir1_acc_addr", first_acc_after_addr, 32'h100);
        check("redir1_pop_pc", first_pop_after_pc, 32'h100);

        // redirect coinciding with a live response
        do_reset();
        set_knobs(100, 100, 2, 2, 0);
        repeat (4) step();
        redir_target = 32'h0000_2002;
        redir_fired  = 1'b0;
        redir_mode   = 2;
        repeat (20) step();
        check("redir2_fired", {31'd0, redir_fired}, 32'd1);
        check("redir2_pop_pc", first_pop_after_pc, 32'h2000);

        // memory not ready for 4 cycles
        do_reset();
        set_knobs(0, 100, 1, 1, 0);
        repeat (4) step();
        check("noready_n_acc", 32'(acc_addr.size()), 32'd0);
        k_rdy_pct = 100;
        repeat (4) step();
        check("noready_first", acc_addr.size() > 0 ? acc_addr[0] : 32'hDEAD_BEEF, 32'h0);

        // randomized traffic with occasional redirects
        do_reset();
        set_knobs(70, 70, 1, 4, 3);
        repeat (3000) step();
        set_knobs(100, 30, 1, 2, 8);
        repeat (1000) step();

        // asynchronous reset mid-stream with fetches in flight
        do_reset();
        set_knobs(100, 0, 3, 3, 0);
        repeat (5) step();
        check("prerst_inflight", 32'(mem_q.size() + exp_q.size() >= 2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        check("arst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("arst_inst", o_inst, 32'd0);
        check("arst_inst_pc", o_inst_pc, 32'd0);
        drive_idle();
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        set_knobs(100, 100, 1, 2, 0);
        repeat (10) step();
        check("postrst_first", acc_addr.size() > 0 ? acc_addr[0] : 32'hDEAD_BEEF, RESET_ADDR);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the pipelined hart. It replaces the combinational imem port with a realistic request/response memory interface. It owns the PC, issues in-order word fetches and pairs each returned instruction with its PC. Instructions are presented to decode through a valid/ready handshake, and the stage flushes on redirects from execute.

Parameters:
RESET_ADDR, 32'h00000000, PC value after reset.
DEPTH, 2, fetch buffer entries; also the maximum number of in-flight plus buffered fetches (power of 2, at least 2).

Ports:
clk  input  1  global clock
rst_n  input  1  reset; asynchronous, active-low
o_imem_req_valid  output  1  fetch request valid
o_imem_req_addr  output  32  word-aligned fetch address
i_imem_req_ready  input  1  memory accepts request this cycle
i_imem_rsp_valid  input  1  response valid; responses return in order, at least 1 cycle after acceptance
i_imem_rsp_rdata  input  32  instruction word
i_redirect_valid  input  1  taken branch/jump/trap redirect from execute
i_redirect_pc  input  32  redirect target
o_inst_valid  output  1  instruction available to decode
o_inst  output  32  instruction word
o_inst_pc  output  32  PC of o_inst
i_inst_ready  input  1  decode consumes instruction

Behaviour:
- Reset (async assert, sync release): pc=RESET_ADDR; all buffer entries free; drop_cnt=0; o_imem_req_valid=0; o_inst_valid=0; o_inst=0; o_inst_pc=0.
- Buffer: circular, DEPTH entries, each {pc, inst, filled}. Three pointers: alloc (tail), fill, head. Entry count = allocated entries, 0..DEPTH.
- Issue: o_imem_req_valid = (count<DEPTH) && !i_redirect_valid; o_imem_req_addr = {pc[31:2],2'b00}.
- On valid&&ready: allocate entry {pc, filled=0}; pc <= pc+4. Wrap-around is modulo 2^32.
- Response: if drop_cnt>0, discard and decrement drop_cnt. Otherwise write inst into the entry at fill, set filled, and advance fill. A response when no unfilled entry exists and drop_cnt=0 is a protocol violation; ignore it.
- Output: o_inst_valid = entry at head filled. o_inst and o_inst_pc come from the head entry, driven from registers (no combinational path from rsp to o_inst). Minimum fetch-to-decode latency is memory latency + 1 cycle.
- Pop on o_inst_valid && i_inst_ready; advance head.
- Full buffer: no request is issued. A response can always be stored, because an entry was reserved at issue.
- Same-cycle allocate, fill and pop are all legal; count = count + alloc - pop.
- Redirect (priority over all else that cycle):
  - pc <= {i_redirect_pc[31:2],2'b00}; misalignment trapping belongs to execute.
  - All entries freed; o_inst_valid=0 next cycle. The current-cycle pop is still honoured but is irrelevant to state.
  - drop_cnt <= drop_cnt + (number of allocated unfilled entries) - (1 if a response arrives this cycle).
  - No request is issued in the redirect cycle. The first request at the new pc is issued the next cycle.
- Back-to-back redirects: each cycle recomputes per the rules above; the last target wins.
- drop_cnt width is clog2(DEPTH)+1 and saturates at DEPTH. By the credit rule it never exceeds DEPTH.
- A new fetch may be issued while drop_cnt>0. Its response is ordered after the dropped ones, so it is correctly kept.

Decomposition:
- Shared package constants: INST_NOP (32'h00000013) and the instruction width (32).
- One sub-module, fetch_buffer, is natural. It holds the DEPTH-entry ring with alloc/fill/pop/flush ports and exposes count, head entry and unfilled count.
- fetch_unit itself holds pc, drop_cnt and the handshake logic.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decode always ready:
  - requests go to 0x0, 0x4, 0x8 on consecutive cycles;
  - o_inst_pc sequence is 0x0, 0x4, 0x8 with matching words;
  - after fill, throughput is 1 instruction per cycle.
- Decode stalled (i_inst_ready=0) for 5 cycles, DEPTH=2:
  - exactly 2 requests are issued (0x0, 0x4); o_imem_req_valid=0 afterwards;
  - when ready returns, 0x0 and 0x4 are presented in order, then fetch resumes at 0x8.
- Redirect to 0x100 while 2 fetches (0x8, 0xC) are in flight with 3-cycle latency:
  - both responses are discarded;
  - first request to 0x100 is issued the cycle after the redirect;
  - decode sees 0x100 next, never 0x8 or 0xC.
- Redirect in the same cycle as a response for an in-flight fetch:
  - that response is dropped and drop_cnt accounts for it exactly;
  - the next retained instruction has pc = the redirect target.
- i_imem_req_ready held low for 4 cycles:
  - o_imem_req_valid stays 1 with addr stable at 0x0;
  - pc does not advance until acceptance.
- rst_n asserted mid-stream with 2 fetches in flight:
  - outputs clear immediately (asynchronously);
  - after release, the first request is to RESET_ADDR and stale responses do not appear at decode (bench withholds them across reset).
